// File: rtl/issue_sched.sv
// issue_sched: dual-issue scheduler between the instruction buffer and execute.
// Decides each cycle how many head entries to pop (0..2) using a register
// scoreboard for long-latency results, structural pairing rules, and a
// drain/serialize FSM for SERIAL-class instructions.
// Optional feature macro: ISSUE_DUAL_EN (when undefined, only entry A issues).
module issue_sched #(
  parameter int SB_REGS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       a_valid,
  input  logic [1:0] a_cls,
  input  logic [4:0] a_dest,
  input  logic [4:0] a_r1,
  input  logic [4:0] a_r2,
  input  logic       b_valid,
  input  logic [1:0] b_cls,
  input  logic [4:0] b_dest,
  input  logic [4:0] b_r1,
  input  logic [4:0] b_r2,
  input  logic       stall,
  input  logic       pipe_empty,
  input  logic       wb_a_valid,
  input  logic [4:0] wb_a_dest,
  input  logic       wb_b_valid,
  input  logic [4:0] wb_b_dest,
  output logic [1:0] o_size,
  output logic       serial_busy
);

  localparam logic [1:0] CLS_MEM = 2'd1;
  localparam logic [1:0] CLS_MUL = 2'd2;
  localparam logic [1:0] CLS_SER = 2'd3;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_POST   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SB_REGS-1:0] busy_q, busy_d;
  logic [SB_REGS-1:0] busy_set_s, busy_clr_s;
  logic               kill_s;
  logic               sb_empty_s;
  logic               issue_a_s;
  logic               issue_b_s;

  // One-hot register mask, all zero when not enabled.
  function automatic logic [SB_REGS-1:0] reg_mask(input logic en, input logic [4:0] idx);
    logic [SB_REGS-1:0] m;
    m = {SB_REGS{1'b0}};
    if (en) begin
      m[idx] = 1'b1;
    end else begin
      m = {SB_REGS{1'b0}};
    end
    return m;
  endfunction

  // Classes whose results come back through the writeback ports.
  function automatic logic long_lat(input logic [1:0] cls);
    return (cls == CLS_MEM) || (cls == CLS_MUL);
  endfunction

  assign kill_s      = reset | flush;
  assign sb_empty_s  = (busy_q == {SB_REGS{1'b0}});
  assign serial_busy = (state_q != ST_NORMAL);

  // Head entry A may issue only in NORMAL with no scoreboard hazard.
  always_comb begin
    issue_a_s = 1'b0;
    if (!kill_s && (state_q == ST_NORMAL) && a_valid && !stall && (a_cls != CLS_SER) &&
        !busy_q[a_r1] && !busy_q[a_r2] && !busy_q[a_dest]) begin
      issue_a_s = 1'b1;
    end else begin
      issue_a_s = 1'b0;
    end
  end

`ifdef ISSUE_DUAL_EN
  logic pair_dep_s;
  logic pair_struct_s;

  // Entry B pairs with A only if independent of A and structurally compatible.
  always_comb begin
    pair_dep_s    = (a_dest != 5'd0) &&
                    ((a_dest == b_r1) || (a_dest == b_r2) || (a_dest == b_dest));
    pair_struct_s = ((a_cls == CLS_MEM) && (b_cls == CLS_MEM)) ||
                    ((a_cls == CLS_MUL) && (b_cls == CLS_MUL));
    issue_b_s     = 1'b0;
    if (issue_a_s && b_valid && (b_cls != CLS_SER) &&
        !busy_q[b_r1] && !busy_q[b_r2] && !busy_q[b_dest] &&
        !pair_dep_s && !pair_struct_s) begin
      issue_b_s = 1'b1;
    end else begin
      issue_b_s = 1'b0;
    end
  end
`else
  // Single-issue build: the B entry fields are deliberately ignored.
  logic unused_b_s;
  assign unused_b_s = ^{b_valid, b_cls, b_dest, b_r1, b_r2};
  assign issue_b_s  = 1'b0;
`endif

  // Scoreboard update: writebacks clear, long-latency issues set; set wins.
  always_comb begin
    busy_set_s = reg_mask(issue_a_s && long_lat(a_cls) && (a_dest != 5'd0), a_dest) |
                 reg_mask(issue_b_s && long_lat(b_cls) && (b_dest != 5'd0), b_dest);
    busy_clr_s = reg_mask(wb_a_valid, wb_a_dest) | reg_mask(wb_b_valid, wb_b_dest);
    if (kill_s) begin
      busy_d = {SB_REGS{1'b0}};
    end else begin
      busy_d = (busy_q & ~busy_clr_s) | busy_set_s;
    end
    busy_d[0] = 1'b0;
  end

  // Serialize FSM next state and pop count.
  always_comb begin
    state_d = state_q;
    o_size  = 2'd0;
    if (kill_s) begin
      state_d = ST_NORMAL;
      o_size  = 2'd0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (issue_b_s) begin
            o_size = 2'd2;
          end else if (issue_a_s) begin
            o_size = 2'd1;
          end else begin
            o_size = 2'd0;
          end
          if (a_valid && (a_cls == CLS_SER)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_NORMAL;
          end
        end
        ST_DRAIN: begin
          if (pipe_empty && sb_empty_s && !stall) begin
            o_size  = 2'd1;
            state_d = ST_POST;
          end else begin
            o_size  = 2'd0;
            state_d = ST_DRAIN;
          end
        end
        ST_POST: begin
          o_size = 2'd0;
          if (pipe_empty) begin
            state_d = ST_NORMAL;
          end else begin
            state_d = ST_POST;
          end
        end
        default: begin
          o_size  = 2'd0;
          state_d = ST_NORMAL;
        end
      endcase
    end
  end

  // State and scoreboard registers; reset/flush are folded into the _d logic.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    busy_q  <= busy_d;
  end

endmodule

// File: doc/issue_sched.md
# issue_sched

Dual-issue scheduler sitting between the instruction buffer and the execute stage. Every cycle it inspects the two head entries presented by the buffer and decides how many to pop: 0, 1 or 2. It does this with a 32-entry register scoreboard for long-latency results, structural pairing rules, and a drain/serialize state machine for CSR, barrier and privileged instructions. Its `o_size` drives the buffer's pop count directly.

## Interface
Parameters:
- `SB_REGS`, 32: architectural registers tracked; r0 is never busy.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `flush`  in  1  pipeline redirect; same effect as reset on all state
- `a_valid`  in  1  head entry valid
- `a_cls`  in  2  class: 0 ALU/branch, 1 MEM, 2 MULDIV, 3 SERIAL
- `a_dest`  in  5  destination register; 0 means no write
- `a_r1`, `a_r2`  in  5 each  source registers; 0 means unused
- `b_valid`, `b_cls`, `b_dest`, `b_r1`, `b_r2`: same fields for the second entry
- `stall`  in  1  backend cannot accept this cycle
- `pipe_empty`  in  1  no instruction in flight past issue
- `wb_a_valid`, `wb_a_dest`  in  1/5  long-latency writeback, pipe A
- `wb_b_valid`, `wb_b_dest`  in  1/5  long-latency writeback, pipe B
- `o_size`  out  2  entries popped this cycle (0..2)
- `serial_busy`  out  1  FSM is not in NORMAL

## Operation
Scoreboard (`busy[31:0]`):
- Bit 0 is hardwired to 0.
- A bit is set when a MEM or MULDIV instruction with a nonzero dest issues.
- A bit is cleared by `wb_*_valid` on the matching dest.
- If a set and a clear hit the same register in the same cycle, the set wins.
- A writeback to a register that is not busy has no effect.
- `sb_empty` means `busy == 0`.

Issue of entry A in NORMAL requires all of:
- `a_valid`
- `!stall`
- `a_cls != SERIAL`
- `busy[a_r1]`, `busy[a_r2]` and `busy[a_dest]` all clear (covers RAW and WAW)

Issue of entry B requires all of:
- A issues this cycle and `b_valid`
- `b_cls != SERIAL`
- No scoreboard hit on `b_r1`, `b_r2` or `b_dest`
- `a_dest == 0`, or `a_dest` differs from each of `b_r1`, `b_r2` and `b_dest`
- Not both entries MEM; not both entries MULDIV

FSM states, transitions evaluated at the clock edge:
- NORMAL:
  - `o_size` follows the rules above.
  - Go to DRAIN when `a_valid && a_cls==SERIAL`. `o_size` is 0 that cycle.
- DRAIN:
  - `o_size` = 0.
  - When `pipe_empty && sb_empty && !stall`: `o_size` = 1 and go to POST.
- POST:
  - `o_size` = 0.
  - When `pipe_empty`: go to NORMAL.
  - At least one cycle is always spent in POST.
- `serial_busy` is 1 in DRAIN and POST.

Reset and flush:
- State returns to NORMAL and `busy` is cleared.
- `o_size` is forced to 0 during the reset/flush cycle.
- A flush mid-DRAIN or mid-POST abandons the serial instruction.

## Timing
- `o_size` is combinational from the inputs, `busy` and state. The buffer pops on the same edge.
- A long-latency dest is busy starting the cycle after issue.
- A writeback clears `busy` at the edge, so a dependent instruction issues no earlier than the cycle after the writeback.
- Minimum serial sequence is 2 cycles from DRAIN entry to NORMAL, when `pipe_empty` and `sb_empty` already hold: DRAIN issues, then POST exits.
- Reset values: state = NORMAL, `busy` = 0, `o_size` = 0, `serial_busy` = 0.

## Configuration
- `ISSUE_DUAL_EN`
  - Defined: B may issue under the rules above.
  - Undefined: B never issues, so `o_size` ≤ 1. The B pairing logic is compiled out; the `b_*` ports remain and are ignored.

## Test plan
- Independent pair: A ALU dest=5, r1=1; B ALU dest=6, r1=2 → `o_size`=2.
- Intra-pair RAW: A ALU dest=7; B ALU r1=7 → `o_size`=1, and B issues as A the next cycle (`o_size`≥1).
- Load-use: MEM dest=8 issues, then ALU r1=8 at head → `o_size`=0 until `wb_a_valid`/`wb_a_dest`=8, then `o_size`=1 the following cycle. Same-cycle writeback and re-issue to r8 leaves `busy[8]`=1.
- Serial: SERIAL at head with `pipe_empty`=0 → DRAIN with `o_size`=0. `pipe_empty`=1 → `o_size`=1 exactly once. POST holds until `pipe_empty`, then NORMAL; `serial_busy` goes 1→0.
- Structural: A MEM, B MEM → `o_size`=1. A MULDIV, B MEM → `o_size`=2. Repeat both with `ISSUE_DUAL_EN` undefined → `o_size`=1 in every case.
- Flush in POST with `busy[3]` set → next cycle NORMAL, `busy`=0, head ALU with r1=3 issues immediately.
